// File: rtl/mac_array_sequencer_if.sv
// Array-side bus of mac_array_sequencer: weight/activation SRAM read strobes, the row-0
// instruction code, and the output-FIFO / column-0 valid feedback from the array.
interface mac_array_sequencer_if #(
    parameter int addr_bw = 11
) ();
    logic               w_rd_en;
    logic [addr_bw-1:0] w_addr;
    logic               x_rd_en;
    logic [addr_bw-1:0] x_addr;
    logic [1:0]         inst_w;
    logic               ofifo_full;
    logic               valid_in;

    modport master (
        output w_rd_en, w_addr, x_rd_en, x_addr, inst_w,
        input  ofifo_full, valid_in
    );

    modport slave (
        input  w_rd_en, w_addr, x_rd_en, x_addr, inst_w,
        output ofifo_full, valid_in
    );
endinterface

// File: rtl/mac_array_sequencer.sv
// Load / settle / execute / drain sequencer for the two-tap mac_tile array.
// Optional SEQ_PERF_CNT_EN adds perf_cycles and perf_stall job counters.
module mac_array_sequencer #(
    parameter int col     = 8,
    parameter int row     = 8,
    parameter int addr_bw = 11,
    parameter int len_bw  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [len_bw-1:0] cfg_len,
    input  logic              cfg_skip_ld,
    output logic              busy,
    output logic              done,
    mac_array_sequencer_if.master arr
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [15:0]       perf_stall
`endif
);
    localparam int LOAD_LEN = 2 * col;
    localparam int TMO      = row + col + 4;
    localparam int CNT_BW   = $clog2((LOAD_LEN > TMO) ? LOAD_LEN : TMO) + 1;
    localparam int NXT_BW   = len_bw + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_EXEC, S_DRAIN, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_BW-1:0]  cnt_q, cnt_d;
    logic [NXT_BW-1:0]  nxt_q, nxt_d;
    logic [len_bw-1:0]  len_q, len_d;
    logic [len_bw-1:0]  vcnt_q, vcnt_d;
    logic               w_rd_en_q, w_rd_en_d;
    logic [addr_bw-1:0] w_addr_q, w_addr_d;
    logic               x_rd_en_q, x_rd_en_d;
    logic [addr_bw-1:0] x_addr_q, x_addr_d;
    logic [1:0]         inst_q;
    logic               busy_q, done_q;
    logic               stall_s;

    // Next state; read strobes and addresses are derived from the next state so they leave registered
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        nxt_d     = nxt_q;
        len_d     = len_q;
        vcnt_d    = vcnt_q;
        w_addr_d  = w_addr_q;
        x_addr_d  = x_addr_q;
        w_rd_en_d = 1'b0;
        x_rd_en_d = 1'b0;
        stall_s   = 1'b0;

        if (state_q != S_IDLE && arr.valid_in && vcnt_q != {len_bw{1'b1}}) begin
            vcnt_d = vcnt_q + len_bw'(1);
        end else begin
            vcnt_d = vcnt_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d    = cfg_len;
                    vcnt_d   = '0;
                    cnt_d    = '0;
                    nxt_d    = '0;
                    w_addr_d = '0;
                    x_addr_d = '0;
                    if (!cfg_skip_ld) begin
                        state_d = S_LOAD;
                    end else if (cfg_len == '0) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_EXEC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (cnt_q == CNT_BW'(LOAD_LEN - 1)) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_BW'(1);
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_BW'(col - 1)) begin
                    cnt_d   = '0;
                    state_d = (len_q == '0) ? S_DRAIN : S_EXEC;
                end else begin
                    cnt_d = cnt_q + CNT_BW'(1);
                end
            end
            S_EXEC: begin
                if (nxt_q == {len_q, 1'b0}) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_DRAIN: begin
                // cnt counts consecutive drain cycles without a valid_in pulse
                if (vcnt_q >= len_q) begin
                    state_d = S_DONE;
                end else begin
                    if (arr.valid_in) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_BW'(1);
                    end
                    if (cnt_d == CNT_BW'(TMO)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_LOAD) begin
            w_rd_en_d = 1'b1;
            w_addr_d  = addr_bw'(cnt_d);
        end else begin
            w_rd_en_d = 1'b0;
        end

        // Backpressure is honoured only before an even (tap0) address, so pairs stay back-to-back
        if (state_d == S_EXEC) begin
            stall_s = !nxt_d[0] && arr.ofifo_full;
            if (!stall_s) begin
                x_rd_en_d = 1'b1;
                x_addr_d  = addr_bw'(nxt_d);
                nxt_d     = nxt_d + NXT_BW'(1);
            end else begin
                x_rd_en_d = 1'b0;
            end
        end else begin
            stall_s = 1'b0;
        end
    end

    // State, counters and registered outputs; inst_w trails the read strobes by one SRAM latency
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            nxt_q     <= '0;
            len_q     <= '0;
            vcnt_q    <= '0;
            w_rd_en_q <= 1'b0;
            w_addr_q  <= '0;
            x_rd_en_q <= 1'b0;
            x_addr_q  <= '0;
            inst_q    <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nxt_q     <= nxt_d;
            len_q     <= len_d;
            vcnt_q    <= vcnt_d;
            w_rd_en_q <= w_rd_en_d;
            w_addr_q  <= w_addr_d;
            x_rd_en_q <= x_rd_en_d;
            x_addr_q  <= x_addr_d;
            inst_q    <= {x_rd_en_q, w_rd_en_q};
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_DONE);
        end
    end

    assign arr.w_rd_en = w_rd_en_q;
    assign arr.w_addr  = w_addr_q;
    assign arr.x_rd_en = x_rd_en_q;
    assign arr.x_addr  = x_addr_q;
    assign arr.inst_w  = inst_q;
    assign busy        = busy_q;
    assign done        = done_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_cycles_q;
    logic [15:0] perf_stall_q;

    // Job cycle and stall counters: cleared on start acceptance, frozen once DONE is reached
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cycles_q <= 32'd0;
            perf_stall_q  <= 16'd0;
        end else if (state_q == S_IDLE && start) begin
            perf_cycles_q <= 32'd0;
            perf_stall_q  <= {15'd0, stall_s};
        end else if (state_q != S_IDLE && state_q != S_DONE) begin
            if (perf_cycles_q != 32'hFFFF_FFFF) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
            if (stall_s && perf_stall_q != 16'hFFFF) begin
                perf_stall_q <= perf_stall_q + 16'd1;
            end
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stall  = perf_stall_q;
`endif
endmodule

// File: tb/tb_mac_array_sequencer.sv
// Scoreboard bench for mac_array_sequencer: jobs are modelled as issue schedules pushed into
// queues, and a negedge monitor pops and compares whatever the DUT presents.
module tb_mac_array_sequencer;
    localparam int COL  = 8;
    localparam int ROW  = 8;
    localparam int ABW  = 11;
    localparam int LBW  = 10;
    localparam int TMO  = ROW + COL + 4;
    localparam int NPAT = 512;

    typedef struct {
        int cyc;
        int val;
        int aux;
    } ev_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [LBW-1:0] cfg_len;
    logic           cfg_skip_ld;
    logic           busy;
    logic           done;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0]    perf_cycles;
    logic [15:0]    perf_stall;
`endif

    mac_array_sequencer_if #(.addr_bw(ABW)) arr ();

    mac_array_sequencer #(.col(COL), .row(ROW), .addr_bw(ABW), .len_bw(LBW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cfg_len     (cfg_len),
        .cfg_skip_ld (cfg_skip_ld),
        .busy        (busy),
        .done        (done),
        .arr         (arr)
`ifdef SEQ_PERF_CNT_EN
        ,
        .perf_cycles (perf_cycles),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  errors = 0;
    int  checks = 0;
    bit  mon_en = 1'b0;
    ev_t wq[$];
    ev_t xq[$];
    ev_t iq[$];
    ev_t dq[$];
    ev_t mev;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic ev_t mk(input int c, input int v, input int a);
        ev_t e;
        e.cyc = c;
        e.val = v;
        e.aux = a;
        return e;
    endfunction

    // Monitor: every strobe, instruction code or done pulse must match the head of its queue
    always @(negedge clk) begin
        if (mon_en) begin
            if (arr.w_rd_en === 1'b1) begin
                if (wq.size() == 0) chk("w_unexpected", 1, 0);
                else begin
                    mev = wq.pop_front();
                    chk("w_cycle", cyc, mev.cyc);
                    chk("w_addr", int'(arr.w_addr), mev.val);
                end
            end
            if (arr.x_rd_en === 1'b1) begin
                if (xq.size() == 0) chk("x_unexpected", 1, 0);
                else begin
                    mev = xq.pop_front();
                    chk("x_cycle", cyc, mev.cyc);
                    chk("x_addr", int'(arr.x_addr), mev.val);
                end
            end
            if (arr.inst_w !== 2'b00) begin
                if (iq.size() == 0) chk("inst_unexpected", int'(arr.inst_w), 0);
                else begin
                    mev = iq.pop_front();
                    chk("inst_cycle", cyc, mev.cyc);
                    chk("inst_code", int'(arr.inst_w), mev.val);
                end
            end
            if (done === 1'b1) begin
                if (dq.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    mev = dq.pop_front();
                    chk("done_cycle", cyc, mev.cyc);
                    chk("busy_at_done", int'(busy), 1);
`ifdef SEQ_PERF_CNT_EN
                    chk("perf_cycles", int'(perf_cycles), mev.aux);
                    chk("perf_stall", int'(perf_stall), mev.val);
`endif
                end
            end
        end
    end

    // One job: build the expected schedule from the sequencing rules, then drive it
    task automatic run_job(input bit skip, input int len, input int nval, input int pct,
                           input int fmode, input bit abort);
        bit fpat[NPAT];
        bit vpat[NPAT];
        int s, t, e, dn, xs, r, fin, i, j, placed, stalls;
        s  = cyc;
        dn = -100;
        r  = -100;
        for (int k = 0; k < NPAT; k++) begin
            fpat[k] = (pct > 0) && (int'($urandom_range(99)) < pct);
            vpat[k] = 1'b0;
        end
        if (fmode == 1) begin
            for (int k = 0; k < NPAT; k++) fpat[k] = 1'b0;
            fpat[2] = 1'b1;
            fpat[3] = 1'b1;
        end
        t = s + 1;
        if (!skip) begin
            for (int k = 0; k < 2 * COL; k++) begin
                wq.push_back(mk(t + k, k, 0));
                iq.push_back(mk(t + k + 1, 1, 0));
            end
            t = t + 3 * COL;
        end
        xs = t;
        stalls = 0;
        for (int k = 0; k < 2 * len; k++) begin
            if (k % 2 == 0) begin
                while ((t - 1 - s) < NPAT && fpat[t - 1 - s]) begin
                    stalls++;
                    t++;
                end
            end
            xq.push_back(mk(t, k, 0));
            iq.push_back(mk(t + 1, 2, 0));
            t++;
        end
        e = t;
        placed = 0;
        while (placed < nval) begin
            j = int'($urandom_range(e - 1 - s, 1));
            if (!vpat[j]) begin
                vpat[j] = 1'b1;
                placed++;
            end
        end
        if (abort) begin
            r = xs + 2;
            while (wq.size() > 0 && wq[$].cyc > r) void'(wq.pop_back());
            while (xq.size() > 0 && xq[$].cyc > r) void'(xq.pop_back());
            while (iq.size() > 0 && iq[$].cyc > r) void'(iq.pop_back());
            fin = r + 3;
        end else begin
            dn = (nval >= len) ? e + 1 : e + TMO;
            dq.push_back(mk(dn, stalls, dn - s - 1));
            fin = dn + 2;
        end

        while (cyc <= fin) begin
            i = cyc - s;
            start          = (i == 0) || (!skip && i == 3);
            cfg_len        = (i == 0) ? LBW'(len) : LBW'($urandom);
            cfg_skip_ld    = (i == 0) ? skip : 1'b1;
            arr.ofifo_full = (i < NPAT) ? fpat[i] : 1'b0;
            arr.valid_in   = (i < NPAT) ? vpat[i] : 1'b0;
            reset          = abort && (cyc == r);
            if (abort && cyc == r + 1) begin
                chk("abort_busy", int'(busy), 0);
                chk("abort_inst", int'(arr.inst_w), 0);
                chk("abort_x_rd_en", int'(arr.x_rd_en), 0);
            end
            if (!abort && cyc == dn + 1) chk("busy_after_done", int'(busy), 0);
            @(negedge clk);
        end
        start          = 1'b0;
        reset          = 1'b0;
        arr.ofifo_full = 1'b0;
        arr.valid_in   = 1'b0;
        chk("w_missing", wq.size(), 0);
        chk("x_missing", xq.size(), 0);
        chk("inst_missing", iq.size(), 0);
        chk("done_missing", dq.size(), 0);
        wq.delete();
        xq.delete();
        iq.delete();
        dq.delete();
    endtask

    initial begin
        int len, nval;
        bit skip;
        reset          = 1'b1;
        start          = 1'b0;
        cfg_len        = '0;
        cfg_skip_ld    = 1'b0;
        arr.ofifo_full = 1'b0;
        arr.valid_in   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_inst", int'(arr.inst_w), 0);
        chk("rst_w_rd_en", int'(arr.w_rd_en), 0);
        chk("rst_x_rd_en", int'(arr.x_rd_en), 0);
        chk("rst_w_addr", int'(arr.w_addr), 0);
        chk("rst_x_addr", int'(arr.x_addr), 0);
`ifdef SEQ_PERF_CNT_EN
        chk("rst_perf_cycles", int'(perf_cycles), 0);
        chk("rst_perf_stall", int'(perf_stall), 0);
`endif
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        run_job(1'b0, 4, 4, 0, 0, 1'b0);   // full load, four pairs, no stall
        run_job(1'b1, 2, 2, 0, 0, 1'b0);   // resident kernel
        run_job(1'b1, 3, 3, 0, 1, 1'b0);   // full rises on odd address 1
        run_job(1'b0, 4, 4, 0, 0, 1'b1);   // reset mid-execute
        run_job(1'b0, 5, 3, 0, 0, 1'b0);   // drain timeout
        run_job(1'b0, 0, 0, 0, 0, 1'b0);   // zero pairs after load
        run_job(1'b1, 0, 0, 0, 0, 1'b0);   // zero pairs, nothing to load
        for (int n = 0; n < 12; n++) begin
            len  = int'($urandom_range(6));
            skip = 1'($urandom_range(1));
            nval = len;
            if (len > 0 && $urandom_range(3) == 0) nval = int'($urandom_range(len - 1));
            run_job(skip, len, nval, 30, 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end
endmodule
